ssm_tile_sched: RTL

Frame-level controller that sequences one SSM step through the SSM block datapath. On start it latches the scalars and walks the tile index over the B/C/hprev buffers. It streams tiles with valid/last tagging into the datapath and waits for the frame's final y. It then returns y with a done pulse, or an error pulse if y never arrives.

---
 rtl/ssm_pkg.sv | 20 ++
 rtl/ssm_tile_sched_if.sv | 36 +++
 rtl/pipe_bus.sv | 23 ++
 rtl/ssm_tile_sched.sv | 104 ++++++++++
 4 files changed

// File: rtl/ssm_pkg.sv
// Shared definitions for the SSM tile scheduler: FSM encoding, defaults and a
// constant clog2 helper usable in parameter expressions.
package ssm_pkg;

  localparam int DW_DEF     = 16;
  localparam int N_TILE_DEF = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_WAIT_Y = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ssm_tile_sched_if.sv
// Bundle of every scheduler-facing signal except clock and reset.
// master = scheduler side, slave = control/buffer/datapath side.
interface ssm_tile_sched_if #(
  parameter int DW     = 16,
  parameter int N_TILE = 16,
  parameter int ADDR_W = 3
);
  logic                   start_i;
  logic [DW-1:0]          dt_i, dA_i, x_i, D_i;
  logic                   busy_o, done_o, err_o;
  logic [DW-1:0]          y_o;
  logic                   mem_rd_en_o;
  logic [ADDR_W-1:0]      mem_rd_addr_o;
  logic [N_TILE*DW-1:0]   B_rd_i, C_rd_i, h_rd_i;
  logic                   tile_valid_o, tile_last_o, tile_ready_i;
  logic [DW-1:0]          dt_o, dA_o, x_o, D_o;
  logic [N_TILE*DW-1:0]   B_tile_o, C_tile_o, hprev_tile_o;
  logic [DW-1:0]          y_final_i;
  logic                   y_final_valid_i;

  modport master (
    input  start_i, dt_i, dA_i, x_i, D_i, B_rd_i, C_rd_i, h_rd_i,
           tile_ready_i, y_final_i, y_final_valid_i,
    output busy_o, done_o, err_o, y_o, mem_rd_en_o, mem_rd_addr_o,
           tile_valid_o, tile_last_o, dt_o, dA_o, x_o, D_o,
           B_tile_o, C_tile_o, hprev_tile_o
  );

  modport slave (
    output start_i, dt_i, dA_i, x_i, D_i, B_rd_i, C_rd_i, h_rd_i,
           tile_ready_i, y_final_i, y_final_valid_i,
    input  busy_o, done_o, err_o, y_o, mem_rd_en_o, mem_rd_addr_o,
           tile_valid_o, tile_last_o, dt_o, dA_o, x_o, D_o,
           B_tile_o, C_tile_o, hprev_tile_o
  );
endinterface

// File: rtl/pipe_bus.sv
// Fixed-depth delay line of W-bit words, D register stages, cleared by reset.
module pipe_bus #(
  parameter int W = 1,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] pipe_reg [D];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < D; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[0] <= d;
      for (int i = 1; i < D; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign q = pipe_reg[D-1];
endmodule

// File: rtl/ssm_tile_sched.sv
// Frame controller: latches scalars, issues one buffer read per tile, tags the
// returning tiles valid/last for the datapath, then waits (bounded) for y.
module ssm_tile_sched
  import ssm_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int N_TILE     = N_TILE_DEF,
  parameter int N_TOTAL    = 128,
  parameter int MEM_RD_LAT = 2,
  parameter int TIMEOUT    = 1024
) (
  input logic             clk,
  input logic             rstn,
  ssm_tile_sched_if.master bus
);
  localparam int NUM_TILES = N_TOTAL / N_TILE;
  localparam int ADDR_W    = (clog2(NUM_TILES) < 1) ? 1 : clog2(NUM_TILES);
  localparam int WD_W      = clog2(TIMEOUT) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TILES - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT - 1);

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] tile_cnt_reg;
  logic [WD_W-1:0]   wd_reg;
  logic [DW-1:0]     dt_reg, da_reg, x_reg, d_reg, y_reg;
  logic              done_reg, err_reg;
  logic              issue, issue_last, tile_valid, tile_last;

  assign issue      = (state_reg == ST_ISSUE) && bus.tile_ready_i;
  assign issue_last = (tile_cnt_reg == LAST_ADDR);

  // Valid and last travel alongside the read so they line up with the data.
  pipe_bus #(.W(1), .D(MEM_RD_LAT)) u_valid_pipe (
    .clk (clk), .rstn (rstn), .d (issue), .q (tile_valid)
  );
  pipe_bus #(.W(1), .D(MEM_RD_LAT)) u_last_pipe (
    .clk (clk), .rstn (rstn), .d (issue && issue_last), .q (tile_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      tile_cnt_reg <= '0;
      wd_reg       <= '0;
      dt_reg       <= '0;
      da_reg       <= '0;
      x_reg        <= '0;
      d_reg        <= '0;
      y_reg        <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: if (bus.start_i) begin
          dt_reg       <= bus.dt_i;
          da_reg       <= bus.dA_i;
          x_reg        <= bus.x_i;
          d_reg        <= bus.D_i;
          tile_cnt_reg <= '0;
          state_reg    <= ST_ISSUE;
        end
        ST_ISSUE: if (issue) begin
          tile_cnt_reg <= tile_cnt_reg + 1'b1;
          if (issue_last) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: if (tile_valid && tile_last) begin
          wd_reg    <= '0;
          state_reg <= ST_WAIT_Y;
        end
        ST_WAIT_Y: begin
          wd_reg <= wd_reg + 1'b1;
          // A y arriving on the timeout cycle still counts as success.
          if (bus.y_final_valid_i) begin
            y_reg     <= bus.y_final_i;
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end else if (wd_reg == WD_LIMIT) begin
            err_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy_o        = (state_reg != ST_IDLE);
  assign bus.done_o        = done_reg;
  assign bus.err_o         = err_reg;
  assign bus.y_o           = y_reg;
  assign bus.mem_rd_en_o   = issue;
  assign bus.mem_rd_addr_o = tile_cnt_reg;
  assign bus.tile_valid_o  = tile_valid;
  assign bus.tile_last_o   = tile_last;
  assign bus.dt_o          = dt_reg;
  assign bus.dA_o          = da_reg;
  assign bus.x_o           = x_reg;
  assign bus.D_o           = d_reg;
  assign bus.B_tile_o      = bus.B_rd_i;
  assign bus.C_tile_o      = bus.C_rd_i;
  assign bus.hprev_tile_o  = bus.h_rd_i;
endmodule
